// File: rtl/bin_decrement_counter.sv
// Registered WIDTH-bit binary decrementer with borrow-out.
// Acts as a wrapping decrementer when idle, or as a one-shot/auto-reload countdown timer after a load.
module bin_decrement_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             dec_en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             borrow,
    output logic             done,
    output logic             zero,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:0]   dec_full;

    // The extra top bit of the subtraction is the borrow out of bit WIDTH-1.
    assign dec_full = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        borrow_d = 1'b0;
        if (load) begin
            count_d  = din;
            reload_d = din;
            state_d  = (din != '0) ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dec_en) begin
                        count_d  = dec_full[WIDTH-1:0];
                        borrow_d = dec_full[WIDTH];
                    end
                end
                S_RUN: begin
                    // A countdown stops at zero instead of wrapping.
                    if (dec_en) begin
                        if (count_q <= {{(WIDTH-1){1'b0}}, 1'b1}) begin
                            count_d = '0;
                            state_d = S_DONE;
                        end else begin
                            count_d = dec_full[WIDTH-1:0];
                        end
                    end
                end
                S_DONE: begin
                    if (auto_reload && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign count     = count_q;
    assign borrow    = borrow_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN);
    assign zero      = (count_q == '0);
    assign dbg_state = state_q;

endmodule
